// File: rtl/frame_seq_pkg.sv
// Shared types and widths for the frame update sequencer.
// State encoding, frame/overrun counter widths and the overrun saturation value.
package frame_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        NEXT
    } seq_state_t;

    localparam int FRAME_CNT_W = 6;
    localparam int OVR_CNT_W   = 8;

    localparam logic [OVR_CNT_W-1:0] OVR_SAT = '1;

endpackage

// File: rtl/frame_update_sequencer_vsync_edge_detect.sv
// VSync falling-edge detector: combinational fall, registered 1-cycle frame_tick and mod-64 frame count.
// The tick and the count update appear one cycle after VS is first sampled low.
module vsync_edge_detect
    import frame_seq_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_vs,
    output logic                   o_fall,
    output logic                   o_frame_tick,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

    logic                   r_vs_d;
    logic                   r_frame_tick;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   w_fall;

    // vs_d resets high so a VS already low at reset release counts as one edge
    assign w_fall = r_vs_d & ~i_vs;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vs_d       <= 1'b1;
            r_frame_tick <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_vs_d       <= i_vs;
            r_frame_tick <= w_fall;
            if (w_fall) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign o_fall       = w_fall;
    assign o_frame_tick = r_frame_tick;
    assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: rtl/frame_update_sequencer.sv
// Per-frame scheduler granting the frame buffer write path to clients 0..N-1 in order, with timeout.
// client_start[0] one cycle after VS is sampled low; next client starts 2 cycles after a done.
module frame_update_sequencer
    import frame_seq_pkg::*;
#(
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   frame_Clk,
    input  logic                   Reset,
    input  logic                   VS,
    input  logic                   enable,
    input  logic [NUM_CLIENTS-1:0] client_mask,
    input  logic [NUM_CLIENTS-1:0] client_done,
    output logic [NUM_CLIENTS-1:0] client_start,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic                   busy,
    output logic                   frame_tick,
    output logic [FRAME_CNT_W-1:0] FrameCount,
    output logic [NUM_CLIENTS-1:0] timeout_err,
    output logic [OVR_CNT_W-1:0]   overrun_cnt
);

    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLIENTS - 1);

    seq_state_t             r_state;
    seq_state_t             w_state_nxt;
    logic [IDX_W-1:0]       r_idx;
    logic [TMR_W-1:0]       r_timer;
    logic [NUM_CLIENTS-1:0] r_timeout_err;
    logic [OVR_CNT_W-1:0]   r_overrun_cnt;

    logic w_fall;
    logic w_sel_mask;
    logic w_sel_done;
    logic w_timer_zero;

    vsync_edge_detect u_vsync_edge_detect (
        .i_clk        (frame_Clk),
        .i_rst        (Reset),
        .i_vs         (VS),
        .o_fall       (w_fall),
        .o_frame_tick (frame_tick),
        .o_frame_cnt  (FrameCount)
    );

    assign w_sel_mask   = client_mask[r_idx];
    assign w_sel_done   = client_done[r_idx];
    assign w_timer_zero = (r_timer == '0);

    always_comb begin
        w_state_nxt  = r_state;
        client_start = '0;
        grant        = '0;
        case (r_state)
            IDLE: begin
                if (w_fall && enable) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_sel_mask) begin
                    client_start[r_idx] = 1'b1;
                    grant[r_idx]        = 1'b1;
                    w_state_nxt         = WAIT;
                end else begin
                    w_state_nxt = NEXT;
                end
            end
            WAIT: begin
                grant[r_idx] = 1'b1;
                if (w_sel_done || w_timer_zero) begin
                    w_state_nxt = NEXT;
                end
            end
            NEXT: begin
                w_state_nxt = (r_idx == IDX_LAST) ? IDLE : START;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge frame_Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_timer       <= '0;
            r_timeout_err <= '0;
            r_overrun_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                START: begin
                    if (w_sel_mask) begin
                        r_timer <= TMR_INIT;
                    end
                end
                // a done arriving on the expiry cycle still counts as success
                WAIT: begin
                    if (!w_sel_done) begin
                        if (w_timer_zero) begin
                            r_timeout_err[r_idx] <= 1'b1;
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                end
                NEXT: begin
                    r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
            if (w_fall && (r_state != IDLE) && (r_overrun_cnt != OVR_SAT)) begin
                r_overrun_cnt <= r_overrun_cnt + 1'b1;
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign timeout_err = r_timeout_err;
    assign overrun_cnt = r_overrun_cnt;

endmodule
